ex_mul_seq_ctrl: RTL

// - Multi-cycle sequencer for the EX-stage multiplier; source of mul_result at the EX result mux.
// - Accepts MUL/MULH/MULHSU/MULHU from EX and runs an iterative shift-add over BITS_PER_CYCLE

---
 rtl/ex_mul_seq_ctrl_pkg.sv | 26 ++
 rtl/ex_mul_step.sv | 27 ++
 rtl/ex_mul_seq_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/ex_mul_seq_ctrl_pkg.sv
// Shared definitions for the EX-stage multiplier sequencer: ALU op codes,
// FSM state encodings and small operand helpers.
package ex_mul_seq_ctrl_pkg;

    localparam logic [3:0] ALU_ADD    = 4'h0;
    localparam logic [3:0] ALU_MUL    = 4'h8;
    localparam logic [3:0] ALU_MULH   = 4'h9;
    localparam logic [3:0] ALU_MULHSU = 4'hA;
    localparam logic [3:0] ALU_MULHU  = 4'hB;

    typedef enum logic [1:0] {
        MULSEQ_IDLE = 2'd0,
        MULSEQ_CALC = 2'd1,
        MULSEQ_DONE = 2'd2
    } mulseq_state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
    endfunction

    // 0x80000000 maps onto itself, which is exactly its unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic negative);
        return negative ? (32'd0 - value) : value;
    endfunction

endpackage

// File: rtl/ex_mul_step.sv
// One combinational shift-add step: consumes BITS_PER_CYCLE multiplier bits,
// adding the matching shifted multiplicands into the accumulator.
module ex_mul_step #(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic [63:0] acc,
    input  logic [63:0] mcand,
    input  logic [31:0] mplier,
    output logic [63:0] acc_next,
    output logic [63:0] mcand_next,
    output logic [31:0] mplier_next
);

    always_comb begin
        // NOTE: blocking assignments here are intentional; each loop pass must see the running sum.
        acc_next = acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) begin
                acc_next = acc_next + (mcand << i);
            end
        end
    end

    assign mcand_next  = mcand << BITS_PER_CYCLE;
    assign mplier_next = mplier >> BITS_PER_CYCLE;

endmodule

// File: rtl/ex_mul_seq_ctrl.sv
// Multi-cycle multiplier sequencer for EX: sign handling, iterative shift-add,
// pipeline stall generation and registered result select.
module ex_mul_seq_ctrl
    import ex_mul_seq_ctrl_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [3:0]  alu_op,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        mul_done,
    output logic [31:0] mul_result
);

    localparam int N  = 32 / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(N - 1);

    mulseq_state_e state, state_next;
    logic [CW-1:0] count;
    logic [3:0]    op_q;
    logic [63:0]   acc, mcand;
    logic [31:0]   mplier;
    logic          neg;

    logic          start, a_signed, b_signed, neg_in, is_zero;
    logic [31:0]   a_mag, b_mag;
    logic [63:0]   step_acc, step_mcand, final_val;
    logic [31:0]   step_mplier;

    assign start    = valid_i & is_mul_op(alu_op) & ~flush_i & (state == MULSEQ_IDLE);
    assign a_signed = (alu_op == ALU_MULH) || (alu_op == ALU_MULHSU);
    assign b_signed = (alu_op == ALU_MULH);
    assign neg_in   = (a_signed & rs1_data[31]) ^ (b_signed & rs2_data[31]);
    assign a_mag    = magnitude(rs1_data, a_signed & rs1_data[31]);
    assign b_mag    = magnitude(rs2_data, b_signed & rs2_data[31]);
    assign is_zero  = (rs1_data == 32'd0) || (rs2_data == 32'd0);

    ex_mul_step #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (step_acc),
        .mcand_next  (step_mcand),
        .mplier_next (step_mplier)
    );

    assign final_val = neg ? (64'd0 - step_acc) : step_acc;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
        if (rst) state <= MULSEQ_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
        state_next = state;
        case (state)
            MULSEQ_IDLE: if (start) state_next = is_zero ? MULSEQ_DONE : MULSEQ_CALC;
            MULSEQ_CALC: if (count == '0) state_next = MULSEQ_DONE;
            MULSEQ_DONE: state_next = MULSEQ_IDLE;
            default:     state_next = MULSEQ_IDLE;
        endcase
        if (flush_i) state_next = MULSEQ_IDLE;
    end

    // A flush releases the pipeline immediately and suppresses the completion pulse.
    assign stall_o  = ~rst & ~flush_i & (start | (state == MULSEQ_CALC));
    assign mul_done = ~rst & ~flush_i & (state == MULSEQ_DONE);

    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too, so mul_result and acc come up at a known zero.
        if (rst) begin
            count      <= '0;
            op_q       <= ALU_ADD;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            neg        <= 1'b0;
            mul_result <= '0;
        end else if (flush_i) begin
            count <= '0;
        end else if (start) begin
            op_q   <= alu_op;
            neg    <= neg_in;
            acc    <= '0;
            mcand  <= {32'd0, a_mag};
            mplier <= b_mag;
            if (is_zero) begin
                count      <= '0;
                mul_result <= '0;
            end else begin
                count <= COUNT_LAST;
            end
        end else if (state == MULSEQ_CALC) begin
            acc    <= step_acc;
            mcand  <= step_mcand;
            mplier <= step_mplier;
            if (count == '0) begin
                mul_result <= (op_q == ALU_MUL) ? final_val[31:0] : final_val[63:32];
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
